// File: rtl/adc_ingress_packer.sv
// Multi-channel ADC ingress: captures NUM_CH lanes per sample set, buffers them in a FIFO and
// emits framed AXI-Stream beats. Optional counter test pattern under ADC_INGRESS_TESTPAT_EN.
module adc_ingress_packer #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADC_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_LEN  = 256,
  localparam int unsigned DATA_W    = NUM_CH * ADC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              test_mode,
  input  logic              clear_stats,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] FifoFull = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LastBeat = BW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     beat_cnt_q;
  logic              drop_pending_q;
  logic              overflow_q;
  logic [15:0]       drop_count_q;

  logic              fifo_full, fifo_empty;
  logic              wr_en, drop, hs;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W:0]   head;
  logic              last_of_frame, last_of_drain;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  assign wr_en      = (state_q == StRun) && adc_valid && !fifo_full;
  assign drop       = (state_q == StRun) && adc_valid && fifo_full;
  assign hs         = m_tvalid && m_tready;

`ifdef ADC_INGRESS_TESTPAT_EN
  logic [ADC_W-1:0] pat_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt_q <= '0;
    end else if (wr_en) begin
      pat_cnt_q <= pat_cnt_q + ADC_W'(1);
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  // Lane source selection and ch_en masking
  always_comb begin
    logic [ADC_W-1:0] lane;
    wr_data = '0;
    lane    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lane = adc_data[k*ADC_W +: ADC_W];
`ifdef ADC_INGRESS_TESTPAT_EN
      if (test_mode) begin
        lane = pat_cnt_q + ADC_W'(k);
      end
`endif
      if (ch_en[k]) begin
        wr_data[k*ADC_W +: ADC_W] = lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {drop_pending_q, wr_data};
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, hs})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (hs) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      // Leave as soon as the last beat is taken so busy drops right after it
      StDrain: if (fifo_empty || (count_q == CW'(1) && hs)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Output is the FIFO head; gating keeps idle outputs at zero
  assign head          = mem[rd_ptr_q];
  assign m_tvalid      = !fifo_empty;
  assign last_of_frame = (beat_cnt_q == LastBeat);
  assign last_of_drain = (state_q == StDrain) && (count_q == CW'(1));
  assign m_tdata       = m_tvalid ? head[DATA_W-1:0] : '0;
  assign m_tuser       = m_tvalid && head[DATA_W];
  assign m_tlast       = m_tvalid && (last_of_frame || last_of_drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (state_q != StIdle && state_d == StIdle) begin
      beat_cnt_q <= '0;
    end else if (hs) begin
      beat_cnt_q <= m_tlast ? '0 : beat_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      if (wr_en) begin
        drop_pending_q <= 1'b0;
      end else if (drop) begin
        drop_pending_q <= 1'b1;
      end
      if (clear_stats) begin
        overflow_q   <= 1'b0;
        drop_count_q <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_q <= drop_count_q + 16'd1;
        end
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_ingress_packer.sv
// Scoreboard bench for adc_ingress_packer: a transaction-level model predicts every beat and the
// statistics; a negedge monitor compares them against the DUT.
module tb_adc_ingress_packer;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned ADC_W      = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FRAME_LEN  = 4;
  localparam int unsigned DATA_W     = NUM_CH * ADC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              test_mode = 1'b0;
  logic              clear_stats = 1'b0;
  logic [NUM_CH-1:0] ch_en = '1;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              m_tready = 1'b0;
  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tuser;
  logic              busy;
  logic              overflow;
  logic [15:0]       drop_count;

  adc_ingress_packer #(
    .NUM_CH    (NUM_CH),
    .ADC_W     (ADC_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .test_mode  (test_mode),
    .clear_stats(clear_stats),
    .ch_en      (ch_en),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                user;
    bit                last;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    beat_no = 0;

  // Transaction-level model state
  bit mdl_active, mdl_draining, mdl_dp, mdl_ovf;
  int mdl_occ, mdl_dc, mdl_pos, mdl_pat;

  always @(posedge clk) begin : model
    bit    acc, drp, take, use_pat;
    int    occ_next;
    beat_t b;
    if (rst) begin
      mdl_active = 0; mdl_draining = 0; mdl_dp = 0; mdl_ovf = 0;
      mdl_occ = 0; mdl_dc = 0; mdl_pos = 0; mdl_pat = 0;
      exp_q.delete();
    end else begin
      take = (mdl_occ > 0) && m_tready;
      acc  = mdl_active && !mdl_draining && adc_valid && (mdl_occ < FIFO_DEPTH);
      drp  = mdl_active && !mdl_draining && adc_valid && (mdl_occ == FIFO_DEPTH);
`ifdef ADC_INGRESS_TESTPAT_EN
      use_pat = test_mode;
`else
      use_pat = 0;
`endif
      if (acc) begin
        b.data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_en[k]) begin
            b.data[k*ADC_W +: ADC_W] = use_pat ? ADC_W'((mdl_pat + k) % 65536)
                                               : adc_data[k*ADC_W +: ADC_W];
          end
        end
        b.user = mdl_dp;
        b.last = (mdl_pos == FRAME_LEN - 1);
        exp_q.push_back(b);
        mdl_pos = b.last ? 0 : mdl_pos + 1;
        mdl_dp  = 0;
        mdl_pat = (mdl_pat + 1) % 65536;
      end
      if (drp) mdl_dp = 1;
      if (clear_stats) begin
        mdl_dc = 0; mdl_ovf = 0;
      end else if (drp) begin
        mdl_ovf = 1;
        if (mdl_dc < 65535) mdl_dc = mdl_dc + 1;
      end
      occ_next = mdl_occ + (acc ? 1 : 0) - (take ? 1 : 0);
      if (!mdl_active) begin
        if (enable) mdl_active = 1;
      end else if (!mdl_draining) begin
        if (!enable) begin
          // The last set accepted in a session closes the frame
          mdl_draining = 1;
          if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1;
          mdl_pos = 0;
        end
      end else if (occ_next == 0) begin
        mdl_active = 0; mdl_draining = 0;
      end
      mdl_occ = occ_next;
    end
  end

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst) begin
      tests++;
      if (m_tvalid !== (mdl_occ > 0)) begin
        fails++;
        $display("FAIL tvalid got %b want %b at %0t", m_tvalid, mdl_occ > 0, $time);
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat%0d unexpected got data %h", beat_no, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tuser !== e.user || m_tlast !== e.last) begin
            fails++;
            $display("FAIL beat%0d got data %h user %b last %b want data %h user %b last %b",
                     beat_no, m_tdata, m_tuser, m_tlast, e.data, e.user, e.last);
          end
        end
        beat_no++;
      end
      tests++;
      if (busy !== mdl_active || overflow !== mdl_ovf || drop_count !== 16'(mdl_dc)) begin
        fails++;
        $display("FAIL stats got busy %b ovf %b cnt %0d want busy %b ovf %b cnt %0d",
                 busy, overflow, drop_count, mdl_active, mdl_ovf, mdl_dc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // dmode: 0 counting {n+100,n}, 1 random, 2 fixed ABCD1234
  // rmode: 0 ready high, 1 ready low while loading, 2 random ready
  task automatic load(input int n, input int dmode, input int rmode, input int clr_at);
    enable = 1; adc_valid = 0; m_tready = (rmode == 0);
    cyc();
    for (int i = 0; i < n; i++) begin
      adc_valid = 1;
      unique case (dmode)
        0:       adc_data = {16'(i + 100), 16'(i)};
        1:       adc_data = $urandom;
        default: adc_data = 32'hABCD_1234;
      endcase
      enable      = (i != n - 1);
      clear_stats = (i == clr_at);
      if (rmode == 2) m_tready = 1'($urandom_range(0, 1));
      cyc();
    end
    adc_valid = 0; enable = 0; clear_stats = 0;
  endtask

  task automatic drain(input int rmode);
    int c;
    c = 0;
    while (busy && c < 400) begin
      m_tready  = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      adc_valid = 1'($urandom_range(0, 1));
      adc_data  = $urandom;
      cyc();
      c++;
    end
    adc_valid = 0;
    chk("drain_timeout", 32'(busy), 32'd0);
    m_tready = 0;
    cyc();
  endtask

  initial begin
    adc_valid = 1; enable = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_tlast_tuser", {30'd0, m_tlast, m_tuser}, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stats", {15'd0, overflow, drop_count}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 0; adc_valid = 0; enable = 0;
    cyc();

    // Sustained throughput, frames of four
    ch_en = 2'b11;
    load(8, 0, 0, -1);
    drain(0);

    // Overflow with ready held low
    load(10, 1, 1, -1);
    chk("ovf_drop_count", 32'(drop_count), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(1);

    // Short session after drops: tuser on first beat, tlast from drain
    load(3, 0, 1, -1);
    drain(1);
    load(4, 0, 0, -1);
    drain(0);

    // Lane masking
    ch_en = 2'b01;
    load(1, 2, 0, -1);
    drain(0);
    ch_en = 2'b11;

    // clear_stats coinciding with a drop
    load(12, 1, 1, 9);
    drain(1);
    clear_stats = 1; cyc(); clear_stats = 0; cyc();
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_count", 32'(drop_count), 32'd0);

    for (int s = 0; s < 20; s++) begin
      ch_en     = 2'($urandom);
      test_mode = 1'($urandom_range(0, 1));
      load($urandom_range(1, 20), 1, 2, $urandom_range(0, 40));
      drain(2);
    end
    test_mode = 0; ch_en = 2'b11;

    // Reset mid-frame discards buffered sets
    load(3, 1, 1, -1);
    enable = 1; adc_valid = 1;
    rst = 1; cyc(); rst = 0; enable = 0; adc_valid = 0;
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    cyc();

`ifdef ADC_INGRESS_TESTPAT_EN
    rst = 1; cyc(); rst = 0; cyc();
    test_mode = 1;
    load(3, 1, 0, -1);
    drain(0);
    test_mode = 0;
`endif

    repeat (5) cyc();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
